// File: rtl/nios_system_tec3_irq_pkg.sv
// Shared constants for the interrupt aggregator: register addresses,
// VECTOR register layout and the maximum source count.
package nios_system_tec3_irq_pkg;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_MODE     = 3'd2;
    localparam logic [2:0] ADDR_VECTOR   = 3'd3;
    localparam logic [2:0] ADDR_RAW      = 3'd4;
    localparam logic [2:0] ADDR_OVERFLOW = 3'd5;
    localparam logic [2:0] ADDR_CONTROL  = 3'd6;

    localparam int VEC_VALID_BIT = 15;
    localparam int VEC_IDX_W     = 4;
    localparam int NUM_IRQ_MAX   = 16;

endpackage

// File: rtl/nios_system_tec3_irq_ctrl_if.sv
// 16-bit Avalon-MM slave bus used by the interrupt aggregator.
//   address    : register select (master -> slave)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (slave -> master)
interface nios_system_tec3_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_tec3_irq_prio.sv
// Lowest-index-first priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   valid : at least one request bit is set
//   idx   : index of the lowest set request bit (0 when none)
module nios_system_tec3_irq_prio
    import nios_system_tec3_irq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]         req,
    output logic                 valid,
    output logic [VEC_IDX_W-1:0] idx
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = VEC_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nios_system_tec3_irq_ctrl.sv
// Interrupt aggregator in front of the Nios II CPU IRQ input.
// Latches per-source pending bits (edge or level mode), applies the mask,
// resolves a lowest-index-first vector and drives one registered irq.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : 16-bit Avalon-MM slave register port
//   irq_in  : source requests, synchronous to clk (bit 0 = interval timer)
//   irq     : registered interrupt to the CPU
module nios_system_tec3_irq_ctrl
    import nios_system_tec3_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    nios_system_tec3_irq_ctrl_if.slave  bus,
    input  logic [NUM_IRQ-1:0]          irq_in,
    output logic                        irq
);

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] ovf_q, ovf_d;
    logic [NUM_IRQ-1:0] irq_in_q;
    logic               ctrl_q, ctrl_d;
    logic               irq_q, irq_d;
    logic [15:0]        readdata_q, readdata_d;

    logic [NUM_IRQ-1:0]   rise;
    logic                 wr;
    logic                 vec_valid;
    logic [VEC_IDX_W-1:0] vec_idx;

    function automatic logic [15:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    nios_system_tec3_irq_prio #(.W(NUM_IRQ)) u_prio (
        .req   (pending_q & mask_q),
        .valid (vec_valid),
        .idx   (vec_idx)
    );

    assign wr   = bus.chipselect & ~bus.write_n;
    assign rise = irq_in & ~irq_in_q;

    always_comb begin
        logic sw_clr;
        logic mode_chg;
        logic clr_eff;
        logic ovf_set;

        mask_d  = mask_q;
        mode_d  = mode_q;
        ctrl_d  = ctrl_q;
        sw_clr  = 1'b0;
        mode_chg = 1'b0;
        clr_eff = 1'b0;
        ovf_set = 1'b0;

        if (wr) begin
            case (bus.address)
                ADDR_MASK:    mask_d = bus.writedata[NUM_IRQ-1:0];
                ADDR_MODE:    mode_d = bus.writedata[NUM_IRQ-1:0];
                ADDR_CONTROL: ctrl_d = bus.writedata[0];
                default:      ;
            endcase
        end

        for (int i = 0; i < NUM_IRQ; i++) begin
            sw_clr = wr && (((bus.address == ADDR_PENDING) && bus.writedata[i]) ||
                            ((bus.address == ADDR_VECTOR) &&
                             (bus.writedata[VEC_IDX_W-1:0] == VEC_IDX_W'(i))));
            mode_chg = wr && (bus.address == ADDR_MODE) &&
                       (bus.writedata[i] != mode_q[i]);
            // Software clears only act on edge-mode bits; a mode switch
            // always drops the bit so stale state never leaks across modes.
            clr_eff = (mode_q[i] & sw_clr) | mode_chg;

            if (mode_chg)
                pending_d[i] = 1'b0;
            else if (!mode_q[i])
                pending_d[i] = irq_in[i];
            else
                pending_d[i] = rise[i] | (pending_q[i] & ~sw_clr);

            ovf_set  = rise[i] & pending_q[i] & ~clr_eff;
            ovf_d[i] = ovf_set | (ovf_q[i] &
                       ~(wr && (bus.address == ADDR_OVERFLOW) && bus.writedata[i]));
        end

        irq_d = ctrl_q & (|(pending_q & mask_q));

        readdata_d = '0;
        case (bus.address)
            ADDR_PENDING:  readdata_d = zext(pending_q);
            ADDR_MASK:     readdata_d = zext(mask_q);
            ADDR_MODE:     readdata_d = zext(mode_q);
            ADDR_VECTOR: begin
                readdata_d[VEC_VALID_BIT]   = vec_valid;
                readdata_d[VEC_IDX_W-1:0]   = vec_idx;
            end
            ADDR_RAW:      readdata_d = zext(irq_in);
            ADDR_OVERFLOW: readdata_d = zext(ovf_q);
            ADDR_CONTROL:  readdata_d[0] = ctrl_q;
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            ovf_q      <= '0;
            irq_in_q   <= '0;
            ctrl_q     <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            irq_in_q   <= irq_in;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign irq          = irq_q;
    assign bus.readdata = readdata_q;

endmodule

// File: doc/nios_system_tec3_irq_ctrl.md
# nios_system_tec3_irq_ctrl

Interrupt aggregator between the interval timer (and up to 15 other peripheral IRQ sources) and the Nios II CPU IRQ input. Latches timer timeouts and other events as per-source pending bits, applies masks, resolves a fixed priority vector, and raises one CPU interrupt. It has the same 16-bit Avalon-MM slave register style as the timer.

## Interface
Parameters:
- NUM_IRQ, 8: number of sources, legal range 1..16. Source 0 is the interval timer `irq`.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq_in  in  NUM_IRQ  source requests, synchronous to clk
- irq  out  1  registered interrupt to CPU

## Operation
Register map. Bits at or above NUM_IRQ read 0 and ignore writes.
- 0 PENDING: read; write-1-to-clear (W1C) on edge-mode bits.
- 1 MASK: read/write, 1 = enabled.
- 2 MODE: read/write, 1 = rising-edge latched, 0 = level.
- 3 VECTOR:
  - Read: bit15 = valid, bits3:0 = lowest-index set bit of PENDING & MASK. Reads 0 when none.
  - Write = ACK: clears the pending bit selected by writedata[3:0]. No effect if that bit is level mode or the index is ≥ NUM_IRQ.
- 4 RAW: read-only, current irq_in.
- 5 OVERFLOW: read; W1C. Set when an edge arrives while that pending bit is already 1 and is not being cleared in the same cycle.
- 6 CONTROL: bit0 = global enable, read/write.
- 7: reads 0, writes ignored.

Edge detection:
- irq_d is a registered copy of irq_in, reset 0.
- edge = irq_in & ~irq_d.
- A source held high through reset release produces one edge on the first clock after reset.

Pending update, per bit:
- Level mode: pending = irq_in, registered. W1C and ACK have no effect.
- Edge mode: set on edge; cleared by W1C bit or ACK. Set and clear in the same cycle: set wins, so no event is lost.
- MODE change: that pending bit is cleared on the same edge as the MODE write.

Interrupt output and reads:
- irq <= CONTROL[0] && |(PENDING & MASK).
- Masking does not clear pending.
- readdata <= mux(address) every cycle, independent of chipselect. Same read behaviour as the timer.

Reset values:
- readdata, PENDING, MASK, MODE, OVERFLOW, CONTROL, irq_d: 0.
- irq: 0.

## Timing
- Edge arriving before clock edge k: PENDING bit set at k; irq asserts at k+1.
- Level input rising before k: PENDING set at k; irq at k+1. Level input falling: PENDING clears at k; irq drops at k+1.
- Write (W1C or ACK) sampled at edge k: bit clear at k; irq deasserts at k+1 if nothing else is pending.
- Read latency: readdata is valid one cycle after address is presented. Zero wait states.
- VECTOR is combinational from the current PENDING & MASK and registered into readdata. A read in the same cycle as an ACK returns the pre-ACK vector.
- Reset is asynchronous at any time. All state clears immediately; irq drops with no clock required.

## Structure
- Package nios_system_tec3_irq_pkg holds:
  - address constants ADDR_PENDING through ADDR_CONTROL (0..6);
  - VEC_VALID_BIT = 15;
  - VEC_IDX_W = 4;
  - NUM_IRQ_MAX = 16.
- One sub-module: nios_system_tec3_irq_prio, a parameterized lowest-index-first priority encoder with outputs valid and idx[3:0].
- All registers live in the top level.

## Test plan
- Reset: hold reset_n low mid-operation with irq=1 → irq and readdata go 0 asynchronously. After release, reads of 0..6 all return 0x0000.
- Timer path:
  - Setup: MODE=0x0001, MASK=0x0001, CONTROL=0x0001. Pulse irq_in[0] for one cycle before edge k.
  - PENDING reads 0x0001; irq=1 at k+1.
  - Write VECTOR=0x0000 → irq=0 one cycle after the write edge.
- Priority:
  - Setup: edge mode, MASK=0x00FF. Pulse sources 5 and 2.
  - VECTOR reads 0x8002. After ACK 2, reads 0x8005. After ACK 5, reads 0x0000.
- Collision:
  - Pending[0]=1. In the same cycle as a W1C PENDING=0x0001, a new edge arrives on irq_in[0].
  - PENDING still reads 0x0001; OVERFLOW reads 0x0000.
- Level mode:
  - Setup: MODE bit1=0, MASK=0x0002, irq_in[1] held high.
  - irq stays 1 through a W1C of 0x0002.
  - Drop irq_in[1] before edge k → PENDING=0 at k; irq=0 at k+1.
- Overflow and mask:
  - Two edges on source 0 with no ACK → OVERFLOW reads 0x0001. W1C 0x0001 clears it.
  - With MASK=0, pending is set but irq stays 0. Setting MASK=1 raises irq one cycle later.
